// File: rtl/i281_dump_pkg.sv
// Shared constants and encodings for the i281 data-memory dump transmitter.
package i281_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [4:0] LAST_BYTE_INDEX = 5'd17;
  localparam int         DATA_BYTES      = 16;
  localparam logic [7:0] DEFAULT_HEADER  = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serialiser: baud counter plus bit-level FSM, tx registered.
module uart_tx_byte
  import i281_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          bit_end;

  assign bit_end = (baud == BAUD_LAST);
  // Ready also covers the final stop-bit cycle so consecutive bytes run gapless.
  assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else if (valid && ready) begin
      state   <= START;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= data;
      tx      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud <= '0;
          tx   <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud  <= '0;
            state <= IDLE;
            tx    <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/datamem_dump_tx.sv
// Snapshots the 16 data-memory bytes and sends them as one framed UART burst:
// header, 16 data bytes, then an 8-bit additive checksum of the snapshot.
module datamem_dump_tx
  import i281_dump_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] datamem0,
  input  logic [7:0] datamem1,
  input  logic [7:0] datamem2,
  input  logic [7:0] datamem3,
  input  logic [7:0] datamem4,
  input  logic [7:0] datamem5,
  input  logic [7:0] datamem6,
  input  logic [7:0] datamem7,
  input  logic [7:0] datamem8,
  input  logic [7:0] datamem9,
  input  logic [7:0] datamem10,
  input  logic [7:0] datamem11,
  input  logic [7:0] datamem12,
  input  logic [7:0] datamem13,
  input  logic [7:0] datamem14,
  input  logic [7:0] datamem15,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [4:0] byte_index
);

  logic [7:0] live   [DATA_BYTES];
  logic [7:0] shadow [DATA_BYTES];
  logic       active;
  logic [7:0] checksum;
  logic [4:0] sel;
  logic [3:0] shadow_idx;
  logic [7:0] tx_data;
  logic       valid;
  logic       ready;
  logic       accept;
  logic       capture;

  assign live[0]  = datamem0;
  assign live[1]  = datamem1;
  assign live[2]  = datamem2;
  assign live[3]  = datamem3;
  assign live[4]  = datamem4;
  assign live[5]  = datamem5;
  assign live[6]  = datamem6;
  assign live[7]  = datamem7;
  assign live[8]  = datamem8;
  assign live[9]  = datamem9;
  assign live[10] = datamem10;
  assign live[11] = datamem11;
  assign live[12] = datamem12;
  assign live[13] = datamem13;
  assign live[14] = datamem14;
  assign live[15] = datamem15;

  // While active the serialiser is always fed the byte after the current one.
  always_comb begin
    sel        = active ? (byte_index + 5'd1) : 5'd0;
    shadow_idx = 4'(sel - 5'd1);
    tx_data    = checksum;
    if (sel == 5'd0) begin
      tx_data = HEADER;
    end else if (sel <= 5'd16) begin
      tx_data = shadow[shadow_idx];
    end
    valid = active ? (byte_index < LAST_BYTE_INDEX) : start;
  end

  assign accept  = valid && ready;
  assign capture = !active && accept;
  assign busy    = active;

  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_shadow
      always_ff @(posedge clock) begin
        if (capture) begin
          shadow[gi] <= live[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      active     <= 1'b0;
      done       <= 1'b0;
      byte_index <= '0;
      checksum   <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (accept) begin
          active     <= 1'b1;
          byte_index <= '0;
          checksum   <= '0;
        end
      end else if (accept) begin
        byte_index <= sel;
        if (sel <= 5'd16) begin
          checksum <= checksum + shadow[shadow_idx];
        end
      end else if (ready) begin
        // Final stop bit of the checksum byte has just completed.
        active     <= 1'b0;
        done       <= 1'b1;
        byte_index <= '0;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock(clock),
    .reset(reset),
    .data (tx_data),
    .valid(valid),
    .ready(ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_datamem_dump_tx.sv
// Self-checking bench for datamem_dump_tx with a UART decoder feeding a byte scoreboard.
module tb_datamem_dump_tx;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dm [16];
  logic       tx;
  logic       busy;
  logic       done;
  logic [4:0] byte_index;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] exp_q [$];
  bit         tim_en = 1'b0;
  int         t0 = 0;
  logic       prev_tx = 1'b1;

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] ck;
    bit         clobber;
    int         mid;
  } vec_t;

  vec_t tv [5];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  datamem_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .start(start),
    .datamem0(dm[0]),   .datamem1(dm[1]),   .datamem2(dm[2]),   .datamem3(dm[3]),
    .datamem4(dm[4]),   .datamem5(dm[5]),   .datamem6(dm[6]),   .datamem7(dm[7]),
    .datamem8(dm[8]),   .datamem9(dm[9]),   .datamem10(dm[10]), .datamem11(dm[11]),
    .datamem12(dm[12]), .datamem13(dm[13]), .datamem14(dm[14]), .datamem15(dm[15]),
    .tx(tx), .busy(busy), .done(done), .byte_index(byte_index)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every tx edge inside a timed frame must sit on a bit boundary.
  always @(negedge clock) begin
    if (tim_en && (tx !== prev_tx)) check("bit_align", (cyc - t0) % CPB, 0);
    prev_tx <= tx;
  end

  // UART decoder: samples mid-bit, checks the full stop bit, scores each byte.
  initial begin : decoder
    logic [7:0] b;
    logic [7:0] e;
    int         hi;
    bit         ab;
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) begin
        b = '0; hi = 0; ab = 1'b0;
        for (int o = 1; o <= 10 * CPB - 1; o++) begin
          @(negedge clock);
          if (reset) ab = 1'b1;
          if (o >= CPB + 2 && o <= 9 * CPB - 2 && (o % CPB) == 2) b[(o - CPB - 2) / CPB] = tx;
          if (o >= 9 * CPB && tx === 1'b1) hi++;
        end
        if (!ab) begin
          check("stop_high_cycles", hi, CPB);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %02h expected none", b);
          end else begin
            e = exp_q.pop_front();
            $display("rx byte %02h expected %02h", b, e);
            check("rx_byte", b, e);
          end
        end
      end
    end
  end

  task automatic load(input logic [7:0] base, input logic [7:0] step, input logic [7:0] ck);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 16; i++) begin
      dm[i] = base + step * 8'(i);
      exp_q.push_back(dm[i]);
    end
    exp_q.push_back(ck);
  endtask

  // Counts negedges from the first start-bit cycle (n=1) until done is seen.
  task automatic wait_done(input int mid, input int hold, input logic [7:0] base,
                           input logic [7:0] step, input logic [7:0] ck,
                           output int n, output int bc);
    n  = 1;
    bc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
      if (busy === 1'b1) bc++;
      if (n == mid) start = 1'b1;
      if (n == mid + 1) start = 1'b0;
      if (n == hold) begin
        start = 1'b1;
        load(base, step, ck);
      end
    end
    check("done_latency", n, 180 * CPB + 1);
    check("busy_cycles", bc, 180 * CPB);
    check("busy_at_done", busy, 0);
  endtask

  task automatic run_frame(input logic [7:0] base, input logic [7:0] step, input logic [7:0] ck,
                           input bit clobber, input int mid, input int hold);
    int n;
    int bc;
    load(base, step, ck);
    @(negedge clock);
    start  = 1'b1;
    t0     = cyc + 1;
    tim_en = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_tx_low", tx, 0);
    check("start_busy", busy, 1);
    if (clobber) for (int i = 0; i < 16; i++) dm[i] = 8'h00;
    wait_done(mid, hold, base, step, ck, n, bc);
    tim_en = 1'b0;
    @(negedge clock);
    check("done_single_cycle", done, 0);
    if (hold != 0) begin
      check("b2b_tx_low", tx, 0);
      check("b2b_busy", busy, 1);
      start = 1'b0;
      wait_done(0, 0, base, step, ck, n, bc);
      @(negedge clock);
      check("done_single_cycle", done, 0);
    end
    check("leftover_bytes", exp_q.size(), 0);
    $display("frame base=%02h step=%02h done after %0d cycles", base, step, n - 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    tv[0] = '{base: 8'h00, step: 8'h01, ck: 8'h78, clobber: 1'b0, mid: 0};
    tv[1] = '{base: 8'hFF, step: 8'h00, ck: 8'hF0, clobber: 1'b1, mid: 0};
    tv[2] = '{base: 8'h10, step: 8'h11, ck: 8'hF8, clobber: 1'b0, mid: 300};
    tv[3] = '{base: 8'h80, step: 8'h00, ck: 8'h00, clobber: 1'b0, mid: 0};
    tv[4] = '{base: 8'h05, step: 8'h0D, ck: 8'h68, clobber: 1'b1, mid: 450};
    for (int i = 0; i < 16; i++) dm[i] = 8'h00;

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outputs", {tx, busy, done, byte_index}, {1'b1, 1'b0, 1'b0, 5'd0});
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      check("idle_outputs", {tx, busy, done, byte_index}, {1'b1, 1'b0, 1'b0, 5'd0});
    end

    // reset and start together: reset wins
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    check("reset_beats_start", {tx, busy}, {1'b1, 1'b0});
    reset = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      run_frame(tv[v].base, tv[v].step, tv[v].ck, tv[v].clobber, tv[v].mid, 0);
      repeat (3) @(negedge clock);
    end

    // start held high across done: second frame follows with no idle bit
    run_frame(8'h21, 8'h03, 8'h78, 1'b0, 0, 700);
    repeat (5) @(negedge clock);

    // reset during data bit 3 of byte_index 5
    load(8'h40, 8'h02, 8'hF0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (n < 5 * 10 * CPB + 4 * CPB + 2) begin
      @(negedge clock);
      n++;
    end
    check("mid_byte_index", byte_index, 5);
    reset = 1'b1;
    @(negedge clock);
    check("mid_reset_outputs", {tx, busy, byte_index}, {1'b1, 1'b0, 5'd0});
    repeat (3) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    repeat (50) @(negedge clock);
    check("post_reset_idle", {tx, busy, done}, {1'b1, 1'b0, 1'b0});
    run_frame(8'h40, 8'h02, 8'hF0, 1'b0, 0, 0);
    repeat (5) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
